// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and stall controller for the 5-stage RV32I pipeline.
// Optional performance counters are compiled in with `define HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 5,
    parameter int LOAD_BUBBLES = 1,
    parameter int MEM_TIMEOUT  = 255,
    parameter int TO_W         = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] rs1_d,
    input  logic [REG_AW-1:0] rs2_d,
    input  logic [REG_AW-1:0] rs1_e,
    input  logic [REG_AW-1:0] rs2_e,
    input  logic [REG_AW-1:0] rd_e,
    input  logic [REG_AW-1:0] rd_m,
    input  logic [REG_AW-1:0] rd_w,
    input  logic              regwen_m,
    input  logic              regwen_w,
    input  logic              memread_e,
    input  logic              memreq_m,
    input  logic              mem_ready,
    input  logic              pc_sel_e,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic              mem_wb_flush,
    output logic [1:0]        forward_a,
    output logic [1:0]        forward_b,
    output logic              mem_err
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       flush_cnt,
    output logic [31:0]       wait_cnt
`endif
);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_LSTALL = 2'd1;
    localparam logic [1:0] S_MWAIT  = 2'd2;
    localparam logic [1:0] S_ERR    = 2'd3;

    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);
    localparam logic [1:0]      BUB_INIT = 2'(LOAD_BUBBLES - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        bub_cnt_q, bub_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [REG_AW-1:0] lu_rd_q, lu_rd_d;
    logic              mem_err_q, mem_err_d;

    logic frozen;
    logic active;
    logic stall;
    logic br_flush;
    logic load_use;
    logic mem_wait;

    // MEM stage wins over WB because it holds the younger result.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic              wen_m,
        input logic [REG_AW-1:0] dst_m,
        input logic              wen_w,
        input logic [REG_AW-1:0] dst_w
    );
        if (wen_m && (dst_m != '0) && (dst_m == rs)) begin
            return 2'b10;
        end else if (wen_w && (dst_w != '0) && (dst_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        forward_a = fwd_sel(rs1_e, regwen_m, rd_m, regwen_w, rd_w);
        forward_b = fwd_sel(rs2_e, regwen_m, rd_m, regwen_w, rd_w);
    end

    assign load_use = memread_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));
    assign mem_wait = memreq_m && !mem_ready;

    always_comb begin
        state_d      = state_q;
        bub_cnt_d    = bub_cnt_q;
        to_cnt_d     = to_cnt_q;
        lu_rd_d      = lu_rd_q;
        mem_err_d    = mem_err_q;
        frozen       = 1'b0;
        active       = 1'b0;
        stall        = 1'b0;
        br_flush     = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_flush     = 1'b0;
        id_ex_flush  = 1'b0;
        mem_wb_flush = 1'b0;

        case (state_q)
            S_ERR: frozen = 1'b1;
            S_MWAIT: begin
                if (!mem_ready) begin
                    frozen = 1'b1;
                    if (to_cnt_q == TO_LIMIT) begin
                        state_d   = S_ERR;
                        mem_err_d = 1'b1;
                    end else begin
                        to_cnt_d = to_cnt_q + TO_ONE;
                    end
                end else begin
                    to_cnt_d = '0;
                    active   = 1'b1;
                end
            end
            default: begin
                if (mem_wait) begin
                    frozen   = 1'b1;
                    state_d  = S_MWAIT;
                    to_cnt_d = TO_ONE;
                end else begin
                    active = 1'b1;
                end
            end
        endcase

        // Pending bubbles survive a memory wait, so the resume cycle consults bub_cnt directly.
        if (active) begin
            if (pc_sel_e) begin
                br_flush  = 1'b1;
                bub_cnt_d = '0;
                state_d   = S_RUN;
            end else if (bub_cnt_q != 2'd0) begin
                stall     = 1'b1;
                bub_cnt_d = bub_cnt_q - 2'd1;
                state_d   = (bub_cnt_q == 2'd1) ? S_RUN : S_LSTALL;
            end else if (load_use) begin
                stall = 1'b1;
                if (LOAD_BUBBLES > 1) begin
                    lu_rd_d   = rd_e;
                    bub_cnt_d = BUB_INIT;
                    state_d   = S_LSTALL;
                end else begin
                    state_d = S_RUN;
                end
            end else begin
                state_d = S_RUN;
            end
        end

        if (br_flush) begin
            if_flush    = 1'b1;
            id_ex_flush = 1'b1;
        end
        if (stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end
        if (frozen) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_flush = 1'b1;
        end

        // While reset is held the pipeline sees plain RUN defaults, independent of inputs.
        if (!reset) begin
            frozen       = 1'b0;
            br_flush     = 1'b0;
            pc_write     = 1'b1;
            if_id_write  = 1'b1;
            id_ex_write  = 1'b1;
            ex_mem_write = 1'b1;
            if_flush     = 1'b0;
            id_ex_flush  = 1'b0;
            mem_wb_flush = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_RUN;
            bub_cnt_q <= 2'd0;
            to_cnt_q  <= '0;
            lu_rd_q   <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bub_cnt_q <= bub_cnt_d;
            to_cnt_q  <= to_cnt_d;
            lu_rd_q   <= lu_rd_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign mem_err = mem_err_q;

    // A multi-bubble stall is only ever opened by a load with a real destination.
    a_lstall_rd: assert property (@(posedge clk) disable iff (!reset)
        (state_q == S_LSTALL) |-> (lu_rd_q != '0));

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] flush_cnt_q, flush_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        if (!pc_write) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (br_flush) begin
            flush_cnt_d = flush_cnt_q + 32'd1;
        end
        if (state_q == S_MWAIT) begin
            wait_cnt_d = wait_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q <= 32'd0;
            flush_cnt_q <= 32'd0;
            wait_cnt_q  <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign wait_cnt  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized and directed bench for pipe_hazard_ctrl against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

    localparam int REG_AW = 5;
    localparam int LB     = 2;
    localparam int TMO    = 8;

    localparam logic [7:0] CTL_DEF = 8'b1101_0100;

    logic              clk;
    logic              reset;
    logic [REG_AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
    logic              regwen_m, regwen_w, memread_e, memreq_m, mem_ready, pc_sel_e;
    logic              pc_write, if_id_write, if_flush, id_ex_write, id_ex_flush;
    logic              ex_mem_write, mem_wb_flush, mem_err;
    logic [1:0]        forward_a, forward_b;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       stall_cnt, flush_cnt, wait_cnt;
`endif

    pipe_hazard_ctrl #(
        .REG_AW(REG_AW),
        .LOAD_BUBBLES(LB),
        .MEM_TIMEOUT(TMO),
        .TO_W(16)
    ) dut (
        .clk(clk),
        .reset(reset),
        .rs1_d(rs1_d),
        .rs2_d(rs2_d),
        .rs1_e(rs1_e),
        .rs2_e(rs2_e),
        .rd_e(rd_e),
        .rd_m(rd_m),
        .rd_w(rd_w),
        .regwen_m(regwen_m),
        .regwen_w(regwen_w),
        .memread_e(memread_e),
        .memreq_m(memreq_m),
        .mem_ready(mem_ready),
        .pc_sel_e(pc_sel_e),
        .pc_write(pc_write),
        .if_id_write(if_id_write),
        .if_flush(if_flush),
        .id_ex_write(id_ex_write),
        .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write),
        .mem_wb_flush(mem_wb_flush),
        .forward_a(forward_a),
        .forward_b(forward_b),
        .mem_err(mem_err)
`ifdef HAZ_PERF_CNT_EN
        ,
        .stall_cnt(stall_cnt),
        .flush_cnt(flush_cnt),
        .wait_cnt(wait_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: waiting on memory, cycles waited, error latched, bubbles left.
    bit m_wait;
    bit m_err;
    int m_waited;
    int m_bub;

    logic [7:0] obs_ctl;
    logic [3:0] obs_fwd;
    logic [7:0] ctl_now;
    assign ctl_now = {pc_write, if_id_write, if_flush, id_ex_write,
                      id_ex_flush, ex_mem_write, mem_wb_flush, mem_err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [REG_AW-1:0] rs);
        if (regwen_m && rd_m != 0 && rd_m == rs) return 2'b10;
        if (regwen_w && rd_w != 0 && rd_w == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_clear();
        m_wait   = 1'b0;
        m_err    = 1'b0;
        m_waited = 0;
        m_bub    = 0;
    endtask

    task automatic idle_inputs();
        rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0;
        rd_e = '0; rd_m = '0; rd_w = '0;
        regwen_m = 1'b0; regwen_w = 1'b0; memread_e = 1'b0;
        memreq_m = 1'b0; mem_ready = 1'b1; pc_sel_e = 1'b0;
    endtask

    // Entered one time unit after a rising edge with inputs already applied.
    task automatic run_cycle(input string tag);
        logic [7:0] exp_ctl;
        bit lu, frz, n_wait, n_err;
        int n_waited, n_bub;
        #2;
        lu  = memread_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
        frz = m_err || (m_wait ? !mem_ready : (memreq_m && !mem_ready));
        n_wait = m_wait; n_err = m_err; n_waited = m_waited; n_bub = m_bub;
        if (frz) begin
            exp_ctl = {7'b0000001, m_err};
            if (!m_err) begin
                if (!m_wait) begin
                    n_wait = 1'b1;
                    n_waited = 1;
                end else if (m_waited >= TMO) begin
                    n_err = 1'b1;
                end else begin
                    n_waited = m_waited + 1;
                end
            end
        end else begin
            exp_ctl  = CTL_DEF;
            n_wait   = 1'b0;
            n_waited = 0;
            if (pc_sel_e) begin
                exp_ctl[5] = 1'b1;
                exp_ctl[3] = 1'b1;
                n_bub = 0;
            end else if (m_bub > 0 || lu) begin
                exp_ctl[7] = 1'b0;
                exp_ctl[6] = 1'b0;
                exp_ctl[3] = 1'b1;
                n_bub = (m_bub > 0) ? m_bub - 1 : LB - 1;
            end
        end
        obs_ctl = ctl_now;
        obs_fwd = {forward_a, forward_b};
        check({tag, "_ctl"}, 32'(obs_ctl), 32'(exp_ctl));
        check({tag, "_fwd"}, 32'(obs_fwd), 32'({ref_fwd(rs1_e), ref_fwd(rs2_e)}));
        @(posedge clk);
        m_wait = n_wait; m_err = n_err; m_waited = n_waited; m_bub = n_bub;
        #1;
    endtask

    // Asserts reset mid-cycle, checks outputs before any edge, releases after the next edge.
    task automatic do_reset(input string tag);
        #2;
        reset = 1'b0;
        #1;
        check({tag, "_rst_ctl"}, 32'(ctl_now), 32'(CTL_DEF));
        check({tag, "_rst_fwd"}, 32'({forward_a, forward_b}), 32'({ref_fwd(rs1_e), ref_fwd(rs2_e)}));
        model_clear();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        model_clear();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("por_ctl", 32'(ctl_now), 32'(CTL_DEF));
        @(posedge clk);
        #1 reset = 1'b1;

        // Forwarding priority.
        regwen_m = 1'b1; rd_m = 5'd5; regwen_w = 1'b1; rd_w = 5'd5; rs1_e = 5'd5; rs2_e = 5'd0;
        run_cycle("fwd_mem");
        check("fwd_mem_a", 32'(obs_fwd[3:2]), 32'(2'b10));
        check("fwd_mem_b", 32'(obs_fwd[1:0]), 32'(2'b00));
        rd_m = 5'd0;
        run_cycle("fwd_wb");
        check("fwd_wb_a", 32'(obs_fwd[3:2]), 32'(2'b01));
        idle_inputs();

        // Load-use with two bubbles.
        memread_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        run_cycle("lu1");
        check("lu1_pcw", 32'(obs_ctl[7]), 32'(0));
        check("lu1_idexf", 32'(obs_ctl[3]), 32'(1));
        memread_e = 1'b0; rd_e = 5'd0;
        run_cycle("lu2");
        check("lu2_pcw", 32'(obs_ctl[7]), 32'(0));
        check("lu2_idexf", 32'(obs_ctl[3]), 32'(1));
        run_cycle("lu3");
        check("lu3_def", 32'(obs_ctl), 32'(CTL_DEF));
        idle_inputs();

        // Memory wait of four cycles, resume on the fifth.
        memreq_m = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            run_cycle("mw");
            check("mw_frozen", 32'(obs_ctl[7:1]), 32'(7'b0000001));
        end
        mem_ready = 1'b1;
        run_cycle("mw_resume");
        check("mw_resume_def", 32'(obs_ctl), 32'(CTL_DEF));
        idle_inputs();

        // Timeout: error appears after eight MWAIT cycles and sticks.
        memreq_m = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            run_cycle("to");
            check("to_err_pre", 32'(obs_ctl[0]), 32'(0));
        end
        run_cycle("to_hit");
        check("to_err_set", 32'(obs_ctl[0]), 32'(1));
        memreq_m = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            run_cycle("err_hold");
            check("err_hold_st", 32'({obs_ctl[7], obs_ctl[0]}), 32'(2'b01));
        end
        do_reset("err");
        run_cycle("post_err");
        check("post_err_def", 32'(obs_ctl), 32'(CTL_DEF));

        // Branch cancels an outstanding load-use bubble.
        memread_e = 1'b1; rd_e = 5'd7; rs2_d = 5'd7;
        run_cycle("br_lu");
        memread_e = 1'b0; rd_e = 5'd0; pc_sel_e = 1'b1;
        run_cycle("br_fl");
        check("br_fl_st", 32'({obs_ctl[7], obs_ctl[5], obs_ctl[3]}), 32'(3'b111));
        pc_sel_e = 1'b0;
        run_cycle("br_after");
        check("br_after_def", 32'(obs_ctl), 32'(CTL_DEF));
        idle_inputs();

        // Reset in the middle of a memory wait, inputs still requesting.
        memreq_m = 1'b1; mem_ready = 1'b0;
        run_cycle("rmw");
        run_cycle("rmw");
        do_reset("rmw");
        idle_inputs();
        run_cycle("rmw_after");

        // Randomized traffic with periodic resets.
        for (int i = 0; i < 600; i++) begin
            if (i % 120 == 119) do_reset("rnd");
            rs1_d = 5'($urandom_range(0, 3));
            rs2_d = 5'($urandom_range(0, 3));
            rs1_e = 5'($urandom_range(0, 3));
            rs2_e = 5'($urandom_range(0, 3));
            rd_e  = 5'($urandom_range(0, 3));
            rd_m  = 5'($urandom_range(0, 3));
            rd_w  = 5'($urandom_range(0, 3));
            regwen_m  = 1'($urandom_range(0, 1));
            regwen_w  = 1'($urandom_range(0, 1));
            memread_e = ($urandom_range(0, 9) < 3);
            memreq_m  = ($urandom_range(0, 9) < 4);
            mem_ready = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 4) != 0);
            pc_sel_e  = ($urandom_range(0, 9) == 0);
            run_cycle("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard, forwarding and stall controller for the 5-stage RV32I pipeline.
- Replaces the separate forwarding unit and load-use detector with one unit.
- Supports a variable-latency data memory through a ready handshake, multi-bubble load-use stalls and branch flush.
- Sits beside the datapath. Drives all pipeline-register write enables and flushes, plus the EX operand forward selects.

Parameters:
REG_AW, 5, register index width (5 gives 32 regs; index 0 is hardwired zero)
LOAD_BUBBLES, 1, bubbles inserted on a load-use hazard (1..3)
MEM_TIMEOUT, 255, max cycles waiting on mem_ready before error (1..2^16-1)
TO_W, 16, timeout counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
rs1_d, rs2_d  in  REG_AW  source regs in ID
rs1_e, rs2_e  in  REG_AW  source regs in EX
rd_e, rd_m, rd_w  in  REG_AW  dest regs in EX/MEM/WB
regwen_m, regwen_w  in  1  reg write enable in MEM/WB
memread_e  in  1  EX instruction is a load
memreq_m  in  1  MEM instruction accesses data memory
mem_ready  in  1  data memory completes access this cycle
pc_sel_e  in  1  taken branch/jump resolved in EX
pc_write  out  1  PC update enable
if_id_write  out  1  IF/ID register enable
if_flush  out  1  IF/ID bubble insert
id_ex_write  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX bubble insert
ex_mem_write  out  1  EX/MEM register enable
mem_wb_flush  out  1  MEM/WB bubble insert
forward_a, forward_b  out  2  00 regfile, 10 from MEM, 01 from WB
mem_err  out  1  sticky memory timeout flag

Behaviour:
- Forwarding (combinational, every cycle)
  - forward_a = 10 if regwen_m && rd_m!=0 && rd_m==rs1_e.
  - Else forward_a = 01 if regwen_w && rd_w!=0 && rd_w==rs1_e.
  - Else forward_a = 00. MEM has priority over WB.
  - forward_b is identical, using rs2_e.
- FSM states: RUN, LSTALL, MWAIT, ERR. Reset enters RUN with bub_cnt=0, to_cnt=0, mem_err=0.
- Defaults: pc_write=if_id_write=id_ex_write=ex_mem_write=1; all flushes=0.
- Frozen (MWAIT and ERR): all write enables=0; mem_wb_flush=1; if_flush=id_ex_flush=0.
- Wait detect: in RUN or LSTALL, if memreq_m && !mem_ready, the unit is frozen this same cycle.
  - Next state is MWAIT, with to_cnt=1.
  - Any LSTALL context (bub_cnt, captured rd) is held, not lost.
- MWAIT
  - Stays frozen while !mem_ready; to_cnt increments each cycle.
  - If to_cnt==MEM_TIMEOUT and still !mem_ready: go to ERR and set mem_err=1.
  - On mem_ready: unfreeze that cycle. Return to LSTALL if bub_cnt!=0, else RUN. Clear to_cnt.
- ERR: frozen until reset. mem_err stays 1.
- Load-use detect (in RUN, not frozen): memread_e && rd_e!=0 && (rd_e==rs1_d || rd_e==rs2_d).
  - That cycle: pc_write=0, if_id_write=0, id_ex_flush=1.
  - If LOAD_BUBBLES>1: capture rd_e, set bub_cnt=LOAD_BUBBLES-1, go to LSTALL.
- LSTALL: same stall outputs while bub_cnt!=0. bub_cnt decrements per unfrozen cycle. Return to RUN at 0.
- Branch flush (not frozen): pc_sel_e gives if_flush=1 and id_ex_flush=1. pc_write stays 1.
  - Branch flush overrides load-use stall: the stall is cancelled, bub_cnt cleared, go to RUN.
  - pc_sel_e while frozen is ignored; the datapath holds it until unfreeze.
- Priority: frozen > branch flush > load-use stall > default.
- Reset asserted mid-stall or mid-wait: immediately enters RUN with defaults and clears mem_err.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- When defined, three extra outputs are added:
  - stall_cnt[31:0]: counts cycles with pc_write=0.
  - flush_cnt[31:0]: counts pc_sel_e flushes.
  - wait_cnt[31:0]: counts MWAIT cycles.
- Counters wrap at 2^32 and reset to 0.
- When undefined, these ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Forwarding: rd_m=5, regwen_m=1, rd_w=5, regwen_w=1, rs1_e=5, rs2_e=0 -> forward_a=10, forward_b=00. With rd_m=0 -> forward_a=01.
- Load-use, LOAD_BUBBLES=2: memread_e=1, rd_e=7, rs2_d=7 -> pc_write=0, id_ex_flush=1 for exactly 2 cycles, then RUN defaults.
- Memory wait: memreq_m=1, mem_ready=0 for 4 cycles then 1 -> all write enables 0 and mem_wb_flush=1 for 4 cycles; resume on the 5th cycle.
- Timeout, MEM_TIMEOUT=8: mem_ready held 0 -> mem_err=1 after 8 wait cycles and stays set. reset=0 -> mem_err=0, state RUN.
- Branch during load stall: LSTALL with bub_cnt=1 and pc_sel_e=1 -> if_flush=1, id_ex_flush=1, pc_write=1. Next cycle shows defaults.
- Reset mid-MWAIT: reset=0 asynchronously -> all outputs return to defaults without waiting for a clock edge.
